// File: rtl/servo_pwm_pkg.sv
// Shared constants, code type and counter-width helper for the servo PWM array.
// Optional write-timeout failsafe is enabled by defining PWM_FAILSAFE_EN.
package servo_pwm_pkg;

    localparam int PWM_WIDTH          = 8;
    localparam int PWM_PRESCALE       = 47;
    localparam int PWM_MIN_TICKS      = 255;
    localparam int PWM_FRAME_TICKS    = 5100;
    localparam int PWM_NEUTRAL        = 127;
    localparam int PWM_TIMEOUT_FRAMES = 25;

    typedef logic [PWM_WIDTH-1:0] pwm_code_t;

    function automatic int cnt_width(input int frame_ticks);
        return $clog2(frame_ticks) + 1;
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One PWM channel: code register, frame-latched code/enable and pulse flop.
// With PWM_FAILSAFE_EN a per-channel frame age counter reverts stale codes.
module servo_pwm_channel
    import servo_pwm_pkg::*;
#(
    parameter int WIDTH          = PWM_WIDTH,
    parameter int CW             = cnt_width(PWM_FRAME_TICKS),
    parameter int MIN_TICKS      = PWM_MIN_TICKS,
    parameter int NEUTRAL        = PWM_NEUTRAL,
    parameter int TIMEOUT_FRAMES = PWM_TIMEOUT_FRAMES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_data,
    input  logic [CW-1:0]    i_count,
    input  logic             i_boundary,
    input  logic             i_pause,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_code,
    output logic             o_pwm,
    output logic             o_stale
);

    logic [WIDTH-1:0] r_code;
    logic [WIDTH-1:0] r_latched;
    logic             r_en_l;
    logic             r_pwm;
    logic [CW-1:0]    w_lim;

    if (TIMEOUT_FRAMES < 1) begin : g_bad_timeout
        $error("TIMEOUT_FRAMES must be at least 1");
    end

    assign w_lim = CW'(MIN_TICKS) + CW'(r_latched);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_latched <= WIDTH'(NEUTRAL);
            r_en_l    <= 1'b0;
            r_pwm     <= 1'b0;
        end else begin
            if (i_boundary) begin
                r_latched <= i_pause ? WIDTH'(NEUTRAL) : r_code;
                r_en_l    <= i_enable;
            end
            r_pwm <= r_en_l & (i_count < w_lim);
        end
    end

`ifdef PWM_FAILSAFE_EN
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);

    logic [TW-1:0] r_age;
    logic          r_stale;

    // A write in the same cycle as a trip takes priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_code  <= WIDTH'(NEUTRAL);
            r_age   <= '0;
            r_stale <= 1'b0;
        end else if (i_wr) begin
            r_code  <= i_data;
            r_age   <= '0;
            r_stale <= 1'b0;
        end else if (i_boundary && r_age != TW'(TIMEOUT_FRAMES)) begin
            r_age <= r_age + 1'b1;
            if (r_age == TW'(TIMEOUT_FRAMES - 1)) begin
                r_code  <= WIDTH'(NEUTRAL);
                r_stale <= 1'b1;
            end
        end
    end

    assign o_stale = r_stale;
`else
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_code <= WIDTH'(NEUTRAL);
        end else if (i_wr) begin
            r_code <= i_data;
        end
    end

    assign o_stale = 1'b0;
`endif

    assign o_code = r_code;
    assign o_pwm  = r_pwm;

endmodule

// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM: shared prescaler and frame counter, per-channel pulses.
// Define PWM_FAILSAFE_EN to build in the per-channel write-timeout failsafe.
module servo_pwm_array
    import servo_pwm_pkg::*;
#(
    parameter int CHANNELS       = 2,
    parameter int WIDTH          = PWM_WIDTH,
    parameter int PRESCALE       = PWM_PRESCALE,
    parameter int MIN_TICKS      = PWM_MIN_TICKS,
    parameter int FRAME_TICKS    = PWM_FRAME_TICKS,
    parameter int NEUTRAL        = PWM_NEUTRAL,
    parameter int TIMEOUT_FRAMES = PWM_TIMEOUT_FRAMES,
    localparam int CHW           = $clog2(CHANNELS) + 1
) (
    input  logic                clk_12MHz,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [CHW-1:0]      chan,
    input  logic [WIDTH-1:0]    wr_data,
    output logic                wr_err,
    output logic [WIDTH-1:0]    rd_data,
    input  logic [CHANNELS-1:0] enable,
    input  logic                pause,
    output logic [CHANNELS-1:0] pwm,
    output logic                frame_start,
    output logic [CHANNELS-1:0] stale
);

    localparam int CW = cnt_width(FRAME_TICKS);
    localparam int PW = $clog2(PRESCALE + 1);

    if (MIN_TICKS + 2**WIDTH - 1 >= FRAME_TICKS) begin : g_bad_frame
        $error("longest pulse does not fit in the frame");
    end

    logic [PW-1:0]    r_pre;
    logic [CW-1:0]    r_count;
    logic             r_frame_start;
    logic             r_wr_err;
    logic             w_tick;
    logic             w_boundary;
    logic             w_valid;
    logic [WIDTH-1:0] w_code [CHANNELS];

    assign w_tick     = (r_pre == PW'(PRESCALE - 1));
    assign w_boundary = w_tick && (r_count == CW'(FRAME_TICKS - 1));
    assign w_valid    = (chan < CHW'(CHANNELS));

    always_ff @(posedge clk_12MHz) begin
        if (!reset) begin
            r_pre         <= '0;
            r_count       <= '0;
            r_frame_start <= 1'b0;
            r_wr_err      <= 1'b0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_count <= w_boundary ? '0 : r_count + 1'b1;
            end
            r_frame_start <= w_boundary;
            r_wr_err      <= wr_en & ~w_valid;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        servo_pwm_channel #(
            .WIDTH          (WIDTH),
            .CW             (CW),
            .MIN_TICKS      (MIN_TICKS),
            .NEUTRAL        (NEUTRAL),
            .TIMEOUT_FRAMES (TIMEOUT_FRAMES)
        ) u_ch (
            .clk        (clk_12MHz),
            .reset      (reset),
            .i_wr       (wr_en && (chan == CHW'(i))),
            .i_data     (wr_data),
            .i_count    (r_count),
            .i_boundary (w_boundary),
            .i_pause    (pause),
            .i_enable   (enable[i]),
            .o_code     (w_code[i]),
            .o_pwm      (pwm[i]),
            .o_stale    (stale[i])
        );
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chan == CHW'(i)) rd_data = w_code[i];
        end
    end

    assign frame_start = r_frame_start;
    assign wr_err      = r_wr_err;

endmodule

// File: tb/tb_servo_pwm_array.sv
// Directed bench for servo_pwm_array with a shortened frame timebase.
// Failsafe steps are included when PWM_FAILSAFE_EN is defined.
module tb_servo_pwm_array;

    localparam int P   = 2;
    localparam int MIN = 20;
    localparam int FR  = 300;
    localparam int NEU = 127;
    localparam int TO  = 20;
    localparam int FP  = P * FR;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] chan = '0;
    logic [7:0] wr_data = '0;
    logic       wr_err;
    logic [7:0] rd_data;
    logic [1:0] enable = '0;
    logic       pause = 1'b0;
    logic [1:0] pwm;
    logic       frame_start;
    logic [1:0] stale;

    int checks = 0;
    int failures = 0;
    int h0, h1;

    always #5 clk = ~clk;

    servo_pwm_array #(
        .CHANNELS       (2),
        .WIDTH          (8),
        .PRESCALE       (P),
        .MIN_TICKS      (MIN),
        .FRAME_TICKS    (FR),
        .NEUTRAL        (NEU),
        .TIMEOUT_FRAMES (TO)
    ) dut (
        .clk_12MHz   (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .chan        (chan),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .rd_data     (rd_data),
        .enable      (enable),
        .pause       (pause),
        .pwm         (pwm),
        .frame_start (frame_start),
        .stale       (stale)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_fs();
        int n = 0;
        @(negedge clk);
        while (!frame_start && n < FP + 10) begin
            @(negedge clk);
            n++;
        end
        if (!frame_start) chk("frame_start_timeout", 0, 1);
    endtask

    // Count high cycles per channel over one frame; act fires mid-frame.
    task automatic measure(input int act, output int a, output int b);
        a = 0;
        b = 0;
        wait_fs();
        for (int k = 0; k < FP; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 10) begin
                case (act)
                    1: begin chan = 2'd1; wr_data = 8'd255; wr_en = 1'b1; end
                    2: begin chan = 2'd0; wr_data = 8'd0; wr_en = 1'b1; end
                    3: pause = 1'b0;
                    4: enable = 2'b10;
                    5: enable = 2'b11;
                    default: ;
                endcase
            end
            if (k == 11) begin
                wr_en = 1'b0;
                if (act == 2) pause = 1'b1;
            end
            a += int'(pwm[0]);
            b += int'(pwm[1]);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_pwm", int'(pwm), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_wr_err", int'(wr_err), 0);
        chk("rst_stale", int'(stale), 0);
        chk("rst_rd_data", int'(rd_data), NEU);

        enable = 2'b11;
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("first_frame_disabled", int'(pwm), 0);

        measure(0, h0, h1);
        chk("neutral_ch0", h0, (MIN + NEU) * P);
        chk("neutral_ch1", h1, (MIN + NEU) * P);

        measure(1, h0, h1);
        chk("midwr_cur_ch1", h1, (MIN + NEU) * P);
        chk("midwr_cur_ch0", h0, (MIN + NEU) * P);
        chan = 2'd1;
        #1 chk("rd_ch1", int'(rd_data), 255);

        measure(0, h0, h1);
        chk("max_ch1", h1, (MIN + 255) * P);
        chk("max_ch0_unchanged", h0, (MIN + NEU) * P);

        measure(2, h0, h1);
        chk("wr0_cur_ch0", h0, (MIN + NEU) * P);
        chk("wr0_cur_ch1", h1, (MIN + 255) * P);

        measure(3, h0, h1);
        chk("pause_ch0", h0, (MIN + NEU) * P);
        chk("pause_ch1", h1, (MIN + NEU) * P);

        measure(0, h0, h1);
        chk("min_ch0", h0, MIN * P);
        chk("unpause_ch1", h1, (MIN + 255) * P);

        @(negedge clk);
        chan = 2'd2;
        wr_data = 8'd99;
        wr_en = 1'b1;
        #1 chk("rd_oor", int'(rd_data), 0);
        @(negedge clk);
        wr_en = 1'b0;
        chk("wr_err_pulse", int'(wr_err), 1);
        @(negedge clk);
        chk("wr_err_clear", int'(wr_err), 0);
        chan = 2'd0;
        #1 chk("rd_ch0", int'(rd_data), 0);

        measure(0, h0, h1);
        chk("oor_ch0", h0, MIN * P);
        chk("oor_ch1", h1, (MIN + 255) * P);

        measure(4, h0, h1);
        chk("dis_cur_ch0", h0, MIN * P);
        measure(5, h0, h1);
        chk("disabled_ch0", h0, 0);
        chk("disabled_ch1", h1, (MIN + 255) * P);
        measure(0, h0, h1);
        chk("reenabled_ch0", h0, MIN * P);

`ifdef PWM_FAILSAFE_EN
        @(negedge clk);
        chan = 2'd0;
        wr_data = 8'd200;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        chk("fs_stale_clear", int'(stale[0]), 0);
        for (int f = 1; f < TO; f++) wait_fs();
        chk("fs_stale_pre", int'(stale[0]), 0);
        wait_fs();
        chk("fs_stale_trip", int'(stale[0]), 1);
        measure(0, h0, h1);
        chk("fs_neutral_ch0", h0, (MIN + NEU) * P);
        @(negedge clk);
        wr_data = 8'd5;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        chk("fs_rewrite_clear", int'(stale[0]), 0);
        #1 chk("fs_rd_ch0", int'(rd_data), 5);
`else
        chk("no_failsafe_stale", int'(stale), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
